fifo_rd_scheduler: RTL

Read-side scheduler for the asynchronous FIFO, living entirely in the read clock domain. It shares the FIFO's single read port among NUM_REQ consumers using round-robin bursts. It drives the FIFO read enable from the FIFO empty flag and steers returned data to the granted consumer with ID and last-beat tagging. An optional starvation timeout aborts bursts when the FIFO stays empty.

---
 rtl/fifo_rd_sched_pkg.sv | 21 ++
 rtl/fifo_rd_scheduler_rr_arbiter.sv | 30 +++
 rtl/fifo_rd_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fifo_rd_sched_pkg.sv
// Shared definitions for the FIFO read-side scheduler: state encoding,
// default widths and the per-consumer burst-length slice helper.
package fifo_rd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_TIMEOUT = 16;

    // Bit offset of consumer idx's field inside the packed req_len bus.
    function automatic int len_lsb(input int idx, input int len_w);
        return idx * len_w;
    endfunction

endpackage

// File: rtl/fifo_rd_scheduler_rr_arbiter.sv
// Combinational rotating-priority select: the search starts at ptr and
// wraps, returning the first eligible consumer as one-hot and as an index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_valid
);

    always_comb begin : pick
        logic [IDX_W-1:0] cand;
        winner    = '0;
        win_idx   = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int off = 0; off < N; off++) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (!any_valid && eligible[cand]) begin
                winner[cand] = 1'b1;
                win_idx      = cand;
                any_valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_scheduler.sv
// Read-domain scheduler sharing one FIFO read port among NUM_REQ consumers
// in round-robin bursts. Define FIFO_RD_SCHED_TIMEOUT_EN for the starvation abort.
module fifo_rd_scheduler
    import fifo_rd_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     rclk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic                     fifo_empty,
    output logic                     fifo_r_en,
    input  logic [DATA_W-1:0]        fifo_rdata,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic [ID_W-1:0]          out_id,
    output logic                     out_last,
    output logic                     done,
    output logic                     abort
);

    if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("fifo_rd_scheduler: NUM_REQ must be >= 2 and TIMEOUT >= 1");
    end

    sched_state_t         state, next_state;
    logic [LEN_W-1:0]     remaining;
    logic [ID_W-1:0]      rr_ptr;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [ID_W-1:0]      win_idx;
    logic                 any_elig;
    logic                 final_read;
    logic                 timeout_hit;
    logic [LEN_W-1:0]     len_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
        assign len_arr[i]  = req_len[len_lsb(i, LEN_W) +: LEN_W];
        assign eligible[i] = req[i] && (len_arr[i] != '0);
    end

    rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
        .eligible  (eligible),
        .ptr       (rr_ptr),
        .winner    (win_onehot),
        .win_idx   (win_idx),
        .any_valid (any_elig)
    );

    assign out_data   = fifo_rdata;
    assign final_read = fifo_r_en && (remaining == LEN_W'(1));

    always_ff @(posedge rclk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        fifo_r_en  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (any_elig) next_state = BURST;
            end
            BURST: begin
                fifo_r_en = !fifo_empty;
                if (!fifo_empty && remaining == LEN_W'(1)) next_state = FLUSH;
                else if (timeout_hit)                      next_state = FLUSH;
            end
            FLUSH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // rr_ptr holds where the next search starts: one past the last winner.
    always_ff @(posedge rclk) begin
        if (rst) begin
            gnt       <= '0;
            remaining <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= fifo_r_en;
            out_last  <= final_read;
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        gnt       <= win_onehot;
                        remaining <= len_arr[win_idx];
                        out_id    <= win_idx;
                    end
                end
                BURST: begin
                    if (fifo_r_en) remaining <= remaining - LEN_W'(1);
                end
                FLUSH: begin
                    gnt    <= '0;
                    rr_ptr <= (out_id == ID_W'(NUM_REQ - 1)) ? '0 : out_id + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_RD_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] empty_cnt;
    logic            aborted;

    assign timeout_hit = (state == BURST) && fifo_empty && (empty_cnt == TO_W'(TIMEOUT - 1));
    assign abort       = aborted;

    // Counts consecutive starved BURST cycles; any read or state exit clears it.
    always_ff @(posedge rclk) begin
        if (rst) begin
            empty_cnt <= '0;
            aborted   <= 1'b0;
        end else begin
            aborted <= timeout_hit;
            if (state == BURST && fifo_empty) empty_cnt <= empty_cnt + TO_W'(1);
            else                              empty_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign abort       = 1'b0;
`endif

endmodule
